// File: rtl/hc_sr04_emulator.sv
// Sensor-side model of an HC-SR04: accepts a trig pulse and answers with an
// echo pulse whose width is (distance+1) units, followed by a dead time.
module hc_sr04_emulator #(
    parameter int clk_frequency   = 50000000,
    parameter int distance_width  = 8,
    parameter int min_trig_cycles = clk_frequency / 100000,
    parameter int burst_cycles    = clk_frequency / 5000,
    parameter int unit_cycles     = clk_frequency / 1000000 * 58,
    parameter int holdoff_cycles  = clk_frequency / 100
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      trig,
    input  logic [distance_width-1:0] distance,
    output logic                      echo,
    output logic                      busy,
    output logic                      done
);

    localparam int TMAX = (burst_cycles > holdoff_cycles) ? burst_cycles : holdoff_cycles;
    localparam int HW   = $clog2(min_trig_cycles + 1);
    localparam int TW   = $clog2(TMAX + 1);
    localparam int UW   = $clog2(unit_cycles + 1);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        BURST,
        ECHO,
        HOLDOFF
    } state_e;

    state_e                    state_q, state_d;
    logic                      sync1_q, trig_s_q, trig_prev_q;
    logic [HW-1:0]             hi_q, hi_d;
    logic [TW-1:0]             tmr_q, tmr_d;
    logic [UW-1:0]             unit_q, unit_d;
    logic [distance_width-1:0] idx_q, idx_d;
    logic [distance_width-1:0] dist_q, dist_d;
    logic                      echo_q, echo_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      trig_rise;

    assign trig_rise = trig_s_q & ~trig_prev_q;
    assign echo      = echo_q;
    assign busy      = busy_q;
    assign done      = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            trig_s_q    <= 1'b0;
            trig_prev_q <= 1'b0;
            state_q     <= IDLE;
            hi_q        <= '0;
            tmr_q       <= '0;
            unit_q      <= '0;
            idx_q       <= '0;
            dist_q      <= '0;
            echo_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            sync1_q     <= trig;
            trig_s_q    <= sync1_q;
            trig_prev_q <= trig_s_q;
            state_q     <= state_d;
            hi_q        <= hi_d;
            tmr_q       <= tmr_d;
            unit_q      <= unit_d;
            idx_q       <= idx_d;
            dist_q      <= dist_d;
            echo_q      <= echo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        tmr_d   = tmr_q;
        unit_d  = unit_q;
        idx_d   = idx_q;
        dist_d  = dist_q;
        unique case (state_q)
            IDLE: begin
                if (trig_rise) begin
                    state_d = TRIG;
                    hi_d    = HW'(1);
                end
            end
            TRIG: begin
                if (trig_s_q) begin
                    if (hi_q < HW'(min_trig_cycles)) hi_d = hi_q + HW'(1);
                end else if (hi_q >= HW'(min_trig_cycles)) begin
                    state_d = BURST;
                    dist_d  = distance;
                    tmr_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                if (tmr_q == TW'(burst_cycles - 1)) begin
                    state_d = ECHO;
                    unit_d  = '0;
                    idx_d   = '0;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            // unit counter nested inside unit-index counter: (dist+1)*unit cycles
            ECHO: begin
                if (unit_q == UW'(unit_cycles - 1)) begin
                    unit_d = '0;
                    if (idx_q == dist_q) begin
                        state_d = HOLDOFF;
                        tmr_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    unit_d = unit_q + UW'(1);
                end
            end
            HOLDOFF: begin
                if (tmr_q == TW'(holdoff_cycles - 1)) state_d = IDLE;
                else tmr_d = tmr_q + TW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        echo_d = (state_d == ECHO);
        busy_d = (state_d != IDLE);
        done_d = (state_q == ECHO) && (state_d == HOLDOFF);
    end

endmodule

// File: tb/tb_hc_sr04_emulator.sv
// Scoreboard bench for hc_sr04_emulator: stimulus queues expected echo
// rise/width and busy-fall cycles, a monitor compares as events appear.
module tb_hc_sr04_emulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trig = 1'b0;
    logic [7:0] distance = 8'd0;
    logic       echo, busy, done;

    hc_sr04_emulator #(
        .clk_frequency  (50000000),
        .distance_width (8),
        .min_trig_cycles(4),
        .burst_cycles   (10),
        .unit_cycles    (3),
        .holdoff_cycles (20)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .trig    (trig),
        .distance(distance),
        .echo    (echo),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int rise;
        int width;
    } exp_t;

    exp_t eq[$];
    int   bq[$];
    int   total = 0;
    int   passed = 0;
    bit   pe = 1'b0;
    bit   pb = 1'b0;
    int   rc = 0;

    task automatic chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: compares echo edges, done and busy falls against queued expectations
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pe = 1'b0;
                pb = 1'b0;
            end else begin
                if (echo && !pe) begin
                    rc = cyc;
                    if (eq.size() == 0) chk("unexpected_echo", 1, 0);
                    else chk("echo_rise_cycle", cyc, eq[0].rise);
                end
                if (!echo && pe && eq.size() != 0) begin
                    e = eq.pop_front();
                    chk("echo_width", cyc - rc, e.width);
                end
                if (done || (pe && !echo)) chk("done_at_echo_fall", int'(done), int'(pe && !echo));
                if (pb && !busy) begin
                    if (bq.size() == 0) chk("unexpected_busy_fall", 1, 0);
                    else chk("busy_fall_cycle", cyc, bq.pop_front());
                end
                pe = echo;
                pb = busy;
            end
        end
    end

    // trig high for n clk cycles; t0 lands 2 edges after the fall is sampled,
    // echo rises 10 edges after t0.
    task automatic pulse(int n, int d, bit valid, bit push);
        exp_t e;
        @(negedge clk);
        distance = 8'(d);
        trig = 1'b1;
        repeat (n) @(negedge clk);
        trig = 1'b0;
        if (push) begin
            if (valid) begin
                e.rise  = cyc + 13;
                e.width = (d + 1) * 3;
                eq.push_back(e);
                bq.push_back(e.rise + e.width + 20);
            end else begin
                bq.push_back(cyc + 3);
            end
        end
    endtask

    task automatic wait_idle(int maxc);
        int k = 0;
        while ((eq.size() != 0 || bq.size() != 0 || busy) && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk("idle_within_budget", int'(k < maxc), 1);
        if (k >= maxc) begin
            eq.delete();
            bq.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_level(bit want, int maxc, string name);
        int k = 0;
        while (echo != want && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk(name, int'(k < maxc), 1);
    endtask

    task automatic wait_busy_low(int maxc);
        int k = 0;
        while (busy && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk("busy_low_within_budget", int'(k < maxc), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_echo", int'(echo), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        pulse(6, 5, 1'b1, 1'b1);
        wait_idle(200);

        pulse(2, 5, 1'b0, 1'b1);
        wait_idle(100);

        pulse(6, 0, 1'b1, 1'b1);
        wait_idle(200);

        pulse(4, 255, 1'b1, 1'b1);
        wait_idle(1200);

        pulse(6, 5, 1'b1, 1'b1);
        wait_level(1'b1, 100, "echo_seen_before_retrig");
        pulse(6, 5, 1'b1, 1'b0);
        wait_idle(200);

        pulse(6, 1, 1'b1, 1'b1);
        wait_level(1'b1, 100, "echo_rise_before_hold");
        wait_level(1'b0, 100, "echo_fall_before_hold");
        @(negedge clk);
        trig = 1'b1;
        wait_busy_low(100);
        repeat (10) @(negedge clk);
        trig = 1'b0;
        repeat (30) @(negedge clk);
        wait_idle(100);

        pulse(6, 5, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        distance = 8'd100;
        wait_idle(200);

        pulse(6, 7, 1'b1, 1'b1);
        wait_level(1'b1, 100, "echo_seen_before_reset");
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midecho_reset_echo", int'(echo), 0);
        chk("midecho_reset_busy", int'(busy), 0);
        chk("midecho_reset_done", int'(done), 0);
        eq.delete();
        bq.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        pulse(6, 3, 1'b1, 1'b1);
        wait_idle(200);

        chk("scoreboard_drained", eq.size() + bq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
